// File: rtl/ex_ctrl_stage.sv
// rtl/ex_ctrl_stage.sv - execute-stage control decode with RV32M latency sequencing
module ex_ctrl_stage #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_ctrl,
  output logic       is_muldiv,
  output logic       illegal,
  output logic       busy,
  output logic [15:0] illegal_cnt
);

  localparam logic [4:0] C_ADD   = 5'b00000;
  localparam logic [4:0] C_SUB   = 5'b00001;
  localparam logic [4:0] C_AND   = 5'b00010;
  localparam logic [4:0] C_OR    = 5'b00011;
  localparam logic [4:0] C_XOR   = 5'b00100;
  localparam logic [4:0] C_SLL   = 5'b00101;
  localparam logic [4:0] C_SRL   = 5'b00110;
  localparam logic [4:0] C_SRA   = 5'b00111;
  localparam logic [4:0] C_SLT   = 5'b01000;
  localparam logic [4:0] C_SLTU  = 5'b01001;
  localparam logic [4:0] C_LUI   = 5'b01010;
  localparam logic [4:0] C_AUIPC = 5'b01011;
  localparam logic [4:0] C_ILL   = 5'b01111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counter preload is LAT-1 so that out_valid rises exactly LAT edges after accept.
  localparam logic [5:0] MUL_LD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic [4:0] dec_ctrl;
  logic       dec_muldiv;
  logic       dec_illegal;
  logic       accept;

  // Shared funct3 table for register and immediate ALU ops; alt picks SUB/SRA.
  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu = alt ? C_SUB : C_ADD;
      3'b001:  base_alu = C_SLL;
      3'b010:  base_alu = C_SLT;
      3'b011:  base_alu = C_SLTU;
      3'b100:  base_alu = C_XOR;
      3'b101:  base_alu = alt ? C_SRA : C_SRL;
      3'b110:  base_alu = C_OR;
      default: base_alu = C_AND;
    endcase
  endfunction

  // Combinational decode of the presented instruction into a control word.
  always_comb begin
    dec_ctrl   = C_ILL;
    dec_muldiv = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            dec_ctrl   = {2'b10, funct3};
            dec_muldiv = 1'b1;
          end
        end else begin
          dec_ctrl = base_alu(funct3, funct7[5]);
        end
      end
      // Immediate ops: funct7[5] is immediate data except for the SRAI shift form.
      OP_I:      dec_ctrl = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
      OP_LUI:    dec_ctrl = C_LUI;
      OP_AUIPC:  dec_ctrl = C_AUIPC;
      OP_LOAD,
      OP_STORE,
      OP_JALR:   dec_ctrl = C_ADD;
      OP_BRANCH: dec_ctrl = C_SUB;
      default:   dec_ctrl = C_ILL;
    endcase
  end

  assign dec_illegal = (dec_ctrl == C_ILL);
  assign in_ready    = (state == S_IDLE) || ((state == S_FULL) && out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign busy        = (state == S_WAIT);

  // Stage sequencer: registers the control word and tracks RV32M latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 6'd0;
      out_valid   <= 1'b0;
      alu_ctrl    <= C_ILL;
      is_muldiv   <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= 16'd0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 6'd0) begin
            state     <= S_FULL;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: begin
          if (accept) begin
            alu_ctrl  <= dec_ctrl;
            is_muldiv <= dec_muldiv;
            illegal   <= dec_illegal;
            if (dec_illegal && (illegal_cnt != 16'hFFFF))
              illegal_cnt <= illegal_cnt + 16'd1;
            if (dec_muldiv) begin
              state     <= S_WAIT;
              cnt       <= funct3[2] ? DIV_LD : MUL_LD;
              out_valid <= 1'b0;
            end else begin
              state     <= S_FULL;
              out_valid <= 1'b1;
            end
          end else if ((state == S_FULL) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_ctrl_stage.sv
// tb/tb_ex_ctrl_stage.sv - scoreboard bench for ex_ctrl_stage
module tb_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        in_ready, out_valid, is_muldiv, illegal, busy;
  logic [4:0]  alu_ctrl;
  logic [15:0] illegal_cnt;

  logic        nm_in_valid, nm_out_ready;
  logic [6:0]  nm_opcode, nm_funct7;
  logic [2:0]  nm_funct3;
  logic        nm_in_ready, nm_out_valid, nm_is_muldiv, nm_illegal, nm_busy;
  logic [4:0]  nm_alu_ctrl;
  logic [15:0] nm_illegal_cnt;

  ex_ctrl_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .is_muldiv(is_muldiv),
    .illegal(illegal), .busy(busy), .illegal_cnt(illegal_cnt)
  );

  ex_ctrl_stage #(.ENABLE_M(0)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .opcode(nm_opcode), .funct3(nm_funct3), .funct7(nm_funct7), .out_valid(nm_out_valid),
    .out_ready(nm_out_ready), .alu_ctrl(nm_alu_ctrl), .is_muldiv(nm_is_muldiv),
    .illegal(nm_illegal), .busy(nm_busy), .illegal_cnt(nm_illegal_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs [0:20];
  logic [4:0] sb [$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         exp_cnt = 0;
  int         n_out = 0;
  bit         mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sat_cnt(input int c);
    return (c > 65535) ? 32'd65535 : 32'(c);
  endfunction

  // Output monitor: compares every produced control word with the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(alu_ctrl), 32'h1F);
      end else begin
        check("alu_ctrl", 32'(alu_ctrl), 32'(sb[0]));
        check("is_muldiv", 32'(is_muldiv), 32'(sb[0][4]));
        check("illegal", 32'(illegal), 32'(sb[0] == 5'b01111));
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end else begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] exp);
    bit done = 1'b0;
    int t = 0;
    opcode = op; funct3 = f3; funct7 = f7; in_valid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        sb.push_back(exp);
        if (exp == 5'b01111) exp_cnt++;
        done = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Counts edges from accept until out_valid; busy=1 and in_ready=0 must hold meanwhile.
  task automatic measure(input string tag, input int lat);
    int k = 0;
    int bad = 0;
    while (!out_valid && k < 100) begin
      if (!busy || in_ready) bad++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_busy"}, 32'(bad), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{R, 3'b000, 7'b0000000, 5'b00000}, '{R, 3'b000, 7'b0100000, 5'b00001},
      '{R, 3'b111, 7'b0000000, 5'b00010}, '{R, 3'b110, 7'b0000000, 5'b00011},
      '{R, 3'b100, 7'b0000000, 5'b00100}, '{R, 3'b001, 7'b0000000, 5'b00101},
      '{R, 3'b101, 7'b0000000, 5'b00110}, '{R, 3'b101, 7'b0100000, 5'b00111},
      '{R, 3'b010, 7'b0000000, 5'b01000}, '{R, 3'b011, 7'b0000000, 5'b01001},
      '{I, 3'b000, 7'b0100000, 5'b00000}, '{I, 3'b101, 7'b0100000, 5'b00111},
      '{I, 3'b101, 7'b0000000, 5'b00110}, '{I, 3'b011, 7'b0100000, 5'b01001},
      '{7'b0110111, 3'b000, 7'b0000000, 5'b01010}, '{7'b0010111, 3'b000, 7'b0000000, 5'b01011},
      '{7'b0000011, 3'b010, 7'b0000000, 5'b00000}, '{7'b0100011, 3'b010, 7'b0000000, 5'b00000},
      '{7'b1100111, 3'b000, 7'b0000000, 5'b00000}, '{7'b1100011, 3'b001, 7'b0000000, 5'b00001},
      '{7'b1111111, 3'b000, 7'b0000000, 5'b01111}
    };
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    nm_in_valid = 1'b0; nm_out_ready = 1'b1;
    nm_opcode = 7'd0; nm_funct3 = 3'd0; nm_funct7 = 7'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, sampled in the reset-release cycle.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0F);
    check("rst_is_muldiv", 32'(is_muldiv), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // RV32M disabled: MUL is illegal and counted.
    nm_opcode = R; nm_funct3 = 3'b000; nm_funct7 = 7'b0000001; nm_in_valid = 1'b1;
    @(posedge clk); #1;
    nm_in_valid = 1'b0;
    check("nm_out_valid", 32'(nm_out_valid), 32'd1);
    check("nm_alu_ctrl", 32'(nm_alu_ctrl), 32'h0F);
    check("nm_illegal", 32'(nm_illegal), 32'd1);
    check("nm_is_muldiv", 32'(nm_is_muldiv), 32'd0);
    check("nm_cnt", 32'(nm_illegal_cnt), 32'd1);
    check("nm_busy", 32'(nm_busy), 32'd0);

    // Base decode table, back-to-back with out_ready=1; every op has latency 1.
    for (int i = 0; i < 21; i++) begin
      send(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].exp);
      check($sformatf("lat1_%0d", i), 32'(out_valid), 32'd1);
    end
    check("cnt_after_table", 32'(illegal_cnt), sat_cnt(exp_cnt));

    // RV32M latencies.
    send(R, 3'b000, 7'b0000001, 5'b10000); measure("mul", 3);
    send(R, 3'b011, 7'b0000001, 5'b10011); measure("mulhu", 3);
    send(R, 3'b101, 7'b0000001, 5'b10101); measure("divu", 33);
    send(R, 3'b110, 7'b0000001, 5'b10110); measure("rem", 33);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Stall: four ops while out_ready is held low for three cycles.
    n_out = 0;
    out_ready = 1'b0;
    fork
      begin
        send(R, 3'b110, 7'b0000000, 5'b00011);
        send(R, 3'b100, 7'b0000000, 5'b00100);
        send(R, 3'b001, 7'b0000000, 5'b00101);
        send(R, 3'b010, 7'b0000000, 5'b01000);
      end
      begin
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("stall_count", 32'(n_out), 32'd4);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Flush at WAIT count 10 with a same-cycle ADD.
    send(R, 3'b101, 7'b0000001, 5'b10101);
    repeat (22) @(posedge clk);
    #1;
    check("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1; in_valid = 1'b1; opcode = R; funct3 = 3'b000; funct7 = 7'b0000000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_cnt", 32'(illegal_cnt), sat_cnt(exp_cnt));
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_out", 32'(n_out), 32'd4);

    // Flush drops a same-cycle illegal op in IDLE without counting it.
    flush = 1'b1; in_valid = 1'b1; opcode = 7'b1111111;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ill_cnt", 32'(illegal_cnt), sat_cnt(exp_cnt));
    check("flush_ill_valid", 32'(out_valid), 32'd0);

    // Reset mid-WAIT aborts the op.
    send(R, 3'b100, 7'b0000001, 5'b10100);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    exp_cnt = 0;
    check("rstw_out_valid", 32'(out_valid), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_in_ready", 32'(in_ready), 32'd1);
    check("rstw_cnt", 32'(illegal_cnt), 32'd0);
    check("rstw_alu_ctrl", 32'(alu_ctrl), 32'h0F);
    repeat (40) @(posedge clk);
    #1;
    check("rstw_no_out", 32'(n_out), 32'd4);

    // Saturation: fill the counter with a stream of illegal ops.
    mon_en = 1'b0;
    opcode = 7'b1111111; funct3 = 3'd0; funct7 = 7'd0; out_ready = 1'b1; in_valid = 1'b1;
    for (int t = 0; t < 70000 && exp_cnt < 65535; t++) begin
      @(negedge clk);
      if (in_ready) exp_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("sat_reach", 32'(illegal_cnt), 32'h0000FFFF);
    send(7'b1111111, 3'b000, 7'b0000000, 5'b01111);
    check("sat_hold", 32'(illegal_cnt), sat_cnt(exp_cnt));
    check("sat_out_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
